// File: rtl/denom_arbiter.sv
// denom_arbiter: round-robin scheduler sharing one Denominator unit among N_REQ requesters.
// A requester's operand is captured on grant, the unit is started with a one-cycle pulse,
// and the result (or a timeout error) is returned to that requester as a one-cycle pulse.
//
// Ports:
//   CLOCK        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   req          in   level request per requester, held until its resp_valid
//   req_x        in   operand per requester, slice i = req_x[32*i+31:32*i]
//   grant        out  one-hot, requester currently being served
//   resp_valid   out  one-cycle pulse to the served requester
//   resp_data    out  result, meaningful only while resp_valid is nonzero
//   resp_err     out  with resp_valid: 1 = timeout (resp_data = 0)
//   dn_start     out  one-cycle start pulse to the Denominator
//   dn_x         out  operand to the Denominator, stable through the transaction
//   dn_reset     out  active-high Denominator reset; held in reset, pulsed on timeout
//   dn_startout  in   Denominator done pulse
//   dn_denom     in   Denominator result
//   busy         out  1 in any state other than IDLE
module denom_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                  CLOCK,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [32*N_REQ-1:0]   req_x,
   output logic [N_REQ-1:0]      grant,
   output logic [N_REQ-1:0]      resp_valid,
   output logic [31:0]           resp_data,
   output logic                  resp_err,
   output logic                  dn_start,
   output logic [31:0]           dn_x,
   output logic                  dn_reset,
   input  logic                  dn_startout,
   input  logic [31:0]           dn_denom,
   output logic                  busy
);

   localparam int unsigned PtrW = $clog2(N_REQ);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q;
   logic [PtrW-1:0]   rr_ptr_q;
   logic [PtrW-1:0]   gnt_idx_q;
   logic [7:0]        wdog_q;

   logic              pick_found;
   logic [PtrW-1:0]   pick_idx;
   logic [N_REQ-1:0]  pick_oh;
   logic [31:0]       pick_x;

   // Round-robin pick: first pass covers rr_ptr..N_REQ-1, second pass wraps to 0..rr_ptr-1.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_oh    = '0;
      pick_x     = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (!pick_found && req[i] && (i >= int'(rr_ptr_q))) begin
            pick_found = 1'b1;
            pick_idx   = PtrW'(i);
            pick_oh[i] = 1'b1;
            pick_x     = req_x[32*i +: 32];
         end
      end
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (!pick_found && req[i] && (i < int'(rr_ptr_q))) begin
            pick_found = 1'b1;
            pick_idx   = PtrW'(i);
            pick_oh[i] = 1'b1;
            pick_x     = req_x[32*i +: 32];
         end
      end
   end

   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         gnt_idx_q  <= '0;
         wdog_q     <= '0;
         grant      <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         dn_start   <= 1'b0;
         dn_x       <= '0;
         dn_reset   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         // Pulsed outputs default low; set only on the cycle that raises them.
         dn_start   <= 1'b0;
         dn_reset   <= 1'b0;
         resp_valid <= '0;
         unique case (state_q)
            StIdle: begin
               if (pick_found) begin
                  grant     <= pick_oh;
                  gnt_idx_q <= pick_idx;
                  dn_x      <= pick_x;
                  busy      <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               dn_start <= 1'b1;
               wdog_q   <= '0;
               state_q  <= StWait;
            end
            StWait: begin
               // A done pulse beats a coincident timeout.
               if (dn_startout) begin
                  resp_data  <= dn_denom;
                  resp_err   <= 1'b0;
                  resp_valid <= grant;
                  state_q    <= StResp;
               end else if (wdog_q == 8'(TIMEOUT)) begin
                  dn_reset   <= 1'b1;
                  resp_data  <= '0;
                  resp_err   <= 1'b1;
                  resp_valid <= grant;
                  state_q    <= StResp;
               end else begin
                  wdog_q <= wdog_q + 8'd1;
               end
            end
            StResp: begin
               rr_ptr_q <= (gnt_idx_q == PtrW'(N_REQ - 1)) ? '0 : gnt_idx_q + PtrW'(1);
               grant    <= '0;
               resp_err <= 1'b0;
               busy     <= 1'b0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
